mandel_scan_ctrl: RTL

MANDEL_SCAN_CTRL -- requirements
Module: mandel_scan_ctrl

---
 rtl/mandel_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mandel_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mandel_scan_ctrl
//
// Raster scan controller for a Mandelbrot renderer. Walks a width x height
// pixel grid for FRAMES frames, presenting each pixel's position and complex
// coordinate c = cr + j*ci to an iteration engine over a valid/ready
// handshake. Pacing gaps are inserted before every line (LINE_WAIT cycles)
// and after every frame (FRAME_WAIT cycles), followed by a one-cycle CLEAR.
//
// Ports
//   sync_clk          sole clock, rising edge
//   rst               synchronous, active-high reset
//   start             run request, sampled only while idle
//   abort             terminate the current run (ignored while idle)
//   width, height     frame size in pixels (latched at start)
//   xstart, ystart    signed Q4.28 origin (latched at start)
//   xincr, yincr      signed Q4.28 per-pixel step (latched at start)
//   eng_valid         pixel request to the engine
//   eng_ready         engine accepts the current request
//   eng_x, eng_y      pixel position of the request
//   eng_cr, eng_ci    complex coordinate of the request
//   busy              a run is in progress
//   flush             pulse after an accepted pixel with x % FLUSH_EVERY == 0
//   frame_done        pulse after the last pixel of a frame is accepted
//   clear             high for the single CLEAR cycle after each frame gap
//   done              pulse when a run ends normally (or a zero-size start)
//
// Optional feature (macro MANDEL_SCAN_PERF_EN):
//   stall_cnt[31:0]   cycles with eng_valid && !eng_ready (saturating)
//   pix_cnt[31:0]     accepted pixels (saturating)
//   Both clear on rst and on a start that launches a run.
// -----------------------------------------------------------------------------
module mandel_scan_ctrl #(
  parameter int DIM_W       = 10,
  parameter int COORD_W     = 32,
  parameter int FRAMES      = 3,
  parameter int LINE_WAIT   = 10,
  parameter int FRAME_WAIT  = 200,
  parameter int FLUSH_EVERY = 10
) (
  input  logic               sync_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   height,
  input  logic [COORD_W-1:0] xstart,
  input  logic [COORD_W-1:0] ystart,
  input  logic [COORD_W-1:0] xincr,
  input  logic [COORD_W-1:0] yincr,
  output logic               eng_valid,
  input  logic               eng_ready,
  output logic [DIM_W-1:0]   eng_x,
  output logic [DIM_W-1:0]   eng_y,
  output logic [COORD_W-1:0] eng_cr,
  output logic [COORD_W-1:0] eng_ci,
  output logic               busy,
  output logic               flush,
  output logic               frame_done,
  output logic               clear,
  output logic               done
`ifdef MANDEL_SCAN_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        pix_cnt
`endif
);

  localparam int WAIT_MAX = (LINE_WAIT > FRAME_WAIT) ? LINE_WAIT : FRAME_WAIT;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam int FL_W     = (FLUSH_EVERY > 1) ? $clog2(FLUSH_EVERY) : 1;

  // Wait counters count down to zero, so the load value is (cycles - 1).
  localparam logic [WAIT_W-1:0] LW_LOAD    = WAIT_W'((LINE_WAIT  > 0) ? LINE_WAIT  - 1 : 0);
  localparam logic [WAIT_W-1:0] FW_LOAD    = WAIT_W'((FRAME_WAIT > 0) ? FRAME_WAIT - 1 : 0);
  localparam logic [FL_W-1:0]   FL_LAST    = FL_W'(FLUSH_EVERY - 1);
  localparam logic [7:0]        FRAME_LOAD = 8'(FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LINE_WAIT,
    S_ISSUE,
    S_FRAME_WAIT,
    S_CLEAR
  } state_t;

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [7:0]          frame_cnt;
  // Tracks eng_x modulo FLUSH_EVERY so no divider is needed.
  logic [FL_W-1:0]     fl_cnt;

  logic [DIM_W-1:0]    w_q, h_q;
  logic [COORD_W-1:0]  xs_q, ys_q, xi_q, yi_q;

  logic start_ok;
  logic accept;
  logic last_x;
  logic last_y;

  assign start_ok = (state == S_IDLE) && start && (width != '0) && (height != '0);
  // abort wins over a same-cycle handshake: that pixel is not accepted.
  assign accept   = (state == S_ISSUE) && eng_ready && !abort;
  assign last_x   = (eng_x == w_q - DIM_W'(1));
  assign last_y   = (eng_y == h_q - DIM_W'(1));

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of its peers, whatever the order of
  // the statements below.
  always_ff @(posedge sync_clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      frame_cnt  <= '0;
      fl_cnt     <= '0;
      w_q        <= '0;
      h_q        <= '0;
      xs_q       <= '0;
      ys_q       <= '0;
      xi_q       <= '0;
      yi_q       <= '0;
      eng_valid  <= 1'b0;
      eng_x      <= '0;
      eng_y      <= '0;
      eng_cr     <= '0;
      eng_ci     <= '0;
      busy       <= 1'b0;
      flush      <= 1'b0;
      frame_done <= 1'b0;
      clear      <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Event outputs are single-cycle pulses unless re-asserted below.
      flush      <= 1'b0;
      frame_done <= 1'b0;
      clear      <= 1'b0;
      done       <= 1'b0;

      if (abort && (state != S_IDLE)) begin
        state     <= S_IDLE;
        eng_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_ok) begin
              w_q       <= width;
              h_q       <= height;
              xs_q      <= xstart;
              ys_q      <= ystart;
              xi_q      <= xincr;
              yi_q      <= yincr;
              frame_cnt <= FRAME_LOAD;
              eng_y     <= '0;
              eng_ci    <= ystart;
              busy      <= 1'b1;
              if (LINE_WAIT == 0) begin
                state     <= S_ISSUE;
                eng_valid <= 1'b1;
                eng_x     <= '0;
                eng_cr    <= xstart;
                fl_cnt    <= '0;
              end else begin
                state    <= S_LINE_WAIT;
                wait_cnt <= LW_LOAD;
              end
            end else if (start) begin
              // Zero-sized frame: nothing to scan, report completion at once.
              done <= 1'b1;
            end
          end

          S_LINE_WAIT: begin
            if (wait_cnt == '0) begin
              state     <= S_ISSUE;
              eng_valid <= 1'b1;
              eng_x     <= '0;
              eng_cr    <= xs_q;
              fl_cnt    <= '0;
            end else begin
              wait_cnt <= wait_cnt - WAIT_W'(1);
            end
          end

          S_ISSUE: begin
            if (accept) begin
              flush  <= (fl_cnt == '0);
              fl_cnt <= (fl_cnt == FL_LAST) ? '0 : fl_cnt + FL_W'(1);
              if (!last_x) begin
                eng_x  <= eng_x + DIM_W'(1);
                eng_cr <= eng_cr + xi_q;
              end else if (!last_y) begin
                eng_y  <= eng_y + DIM_W'(1);
                eng_ci <= eng_ci + yi_q;
                if (LINE_WAIT == 0) begin
                  eng_x  <= '0;
                  eng_cr <= xs_q;
                  fl_cnt <= '0;
                end else begin
                  state     <= S_LINE_WAIT;
                  wait_cnt  <= LW_LOAD;
                  eng_valid <= 1'b0;
                end
              end else begin
                frame_done <= 1'b1;
                eng_valid  <= 1'b0;
                if (FRAME_WAIT == 0) begin
                  state <= S_CLEAR;
                  clear <= 1'b1;
                end else begin
                  state    <= S_FRAME_WAIT;
                  wait_cnt <= FW_LOAD;
                end
              end
            end
          end

          S_FRAME_WAIT: begin
            if (wait_cnt == '0) begin
              state <= S_CLEAR;
              clear <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt - WAIT_W'(1);
            end
          end

          S_CLEAR: begin
            if (frame_cnt == '0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt - 8'd1;
              eng_y     <= '0;
              eng_ci    <= ys_q;
              if (LINE_WAIT == 0) begin
                state     <= S_ISSUE;
                eng_valid <= 1'b1;
                eng_x     <= '0;
                eng_cr    <= xs_q;
                fl_cnt    <= '0;
              end else begin
                state    <= S_LINE_WAIT;
                wait_cnt <= LW_LOAD;
              end
            end
          end

          default: begin
            state     <= S_IDLE;
            eng_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef MANDEL_SCAN_PERF_EN
  always_ff @(posedge sync_clk) begin
    if (rst || start_ok) begin
      stall_cnt <= '0;
      pix_cnt   <= '0;
    end else begin
      if (eng_valid && !eng_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (accept && (pix_cnt != '1)) begin
        pix_cnt <= pix_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
